// File: rtl/mic_array_pkg.sv
// Shared constants and state encoding for the microphone-array pipeline
// (mic_fir, cic, mic_buffer).
package mic_array_pkg;

    localparam int DATA_WIDTH        = 16;
    localparam int CHANNELS          = 8;
    localparam int CHANNELS_WIDTH    = $clog2(CHANNELS);
    localparam int ADDR_WIDTH_BUFFER = 13;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } state_t;

endpackage

// File: rtl/mic_buffer_ram.sv
// Simple dual-port sample RAM: synchronous write, registered read that holds
// its value while no read is requested. Contents are not touched by reset.
module mic_buffer_ram #(
    parameter int DATA_WIDTH = mic_array_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = mic_array_pkg::ADDR_WIDTH_BUFFER
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [0:(2**ADDR_WIDTH)-1];
    logic [DATA_WIDTH-1:0] rdata_d;
    logic [DATA_WIDTH-1:0] rdata_q;

    // Memory array write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Next read-data value: new word on a request, otherwise hold.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[raddr];
        end else begin
            rdata_d = rdata_q;
        end
    end

    // Read-data output register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rdata_q <= {DATA_WIDTH{1'b0}};
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mic_buffer.sv
// Ping-pong sample buffer behind mic_fir: fills one bank while the host reads
// the other. Optional overrun tracking is built when MIC_BUFFER_OVERRUN_EN is defined.
module mic_buffer #(
    parameter int DATA_WIDTH        = mic_array_pkg::DATA_WIDTH,
    parameter int CHANNELS          = mic_array_pkg::CHANNELS,
    parameter int CHANNELS_WIDTH    = mic_array_pkg::CHANNELS_WIDTH,
    parameter int ADDR_WIDTH_BUFFER = mic_array_pkg::ADDR_WIDTH_BUFFER
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         write_data,
    input  logic [CHANNELS_WIDTH-1:0]    channel,
    input  logic [DATA_WIDTH-1:0]        data_in,
    input  logic                         rd_en,
    input  logic [ADDR_WIDTH_BUFFER-2:0] rd_addr,
    output logic [DATA_WIDTH-1:0]        rd_data,
    output logic                         buffer_selector,
    output logic                         bank_ready,
    input  logic                         buffer_ack,
    output logic                         overrun,
    output logic                         sync_err
);

    import mic_array_pkg::*;

    localparam int FRM_W = ADDR_WIDTH_BUFFER - 1 - CHANNELS_WIDTH;
    localparam logic [CHANNELS_WIDTH-1:0] LAST_CH = CHANNELS_WIDTH'(CHANNELS - 1);

    state_t                    state_q, state_d;
    logic                      write_data_q;
    logic [CHANNELS_WIDTH-1:0] exp_ch_q, exp_ch_d;
    logic [FRM_W-1:0]          frame_cnt_q, frame_cnt_d;
    logic                      buffer_selector_q, buffer_selector_d;
    logic                      bank_ready_q, bank_ready_d;
    logic                      sync_err_q, sync_err_d;

    logic                      wr_stb_s;
    logic                      ch_zero_s;
    logic                      wr_en_s;
    logic [CHANNELS_WIDTH-1:0] wr_ch_s;
    logic [FRM_W-1:0]          wr_frm_s;
    logic                      sync_set_s;
    logic                      clr_cnt_s;
    logic                      bank_full_s;

    assign wr_stb_s  = write_data & ~write_data_q;
    assign ch_zero_s = (channel == {CHANNELS_WIDTH{1'b0}});

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: only a channel-0 strobe starts a fill; a non-zero mismatch drops back.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (wr_stb_s && ch_zero_s) begin
                    state_d = ST_FILL;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (wr_stb_s && (channel != exp_ch_q) && !ch_zero_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_FILL;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: write enable, write offset and resync requests.
    always_comb begin
        wr_en_s    = 1'b0;
        wr_ch_s    = exp_ch_q;
        wr_frm_s   = frame_cnt_q;
        sync_set_s = 1'b0;
        clr_cnt_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (wr_stb_s && ch_zero_s) begin
                    wr_en_s  = 1'b1;
                    wr_ch_s  = {CHANNELS_WIDTH{1'b0}};
                    wr_frm_s = {FRM_W{1'b0}};
                end else begin
                    wr_en_s  = 1'b0;
                end
            end
            ST_FILL: begin
                if (!wr_stb_s) begin
                    wr_en_s = 1'b0;
                end else if (channel == exp_ch_q) begin
                    wr_en_s = 1'b1;
                end else if (ch_zero_s) begin
                    // A stray channel 0 restarts the bank at offset 0 instead of waiting.
                    wr_en_s    = 1'b1;
                    wr_ch_s    = {CHANNELS_WIDTH{1'b0}};
                    wr_frm_s   = {FRM_W{1'b0}};
                    sync_set_s = 1'b1;
                end else begin
                    sync_set_s = 1'b1;
                    clr_cnt_s  = 1'b1;
                end
            end
            default: clr_cnt_s = 1'b1;
        endcase
    end

    assign bank_full_s = wr_en_s && (wr_ch_s == LAST_CH) && (&wr_frm_s);

    // Counter, bank select and flag next-state values.
    always_comb begin
        exp_ch_d    = exp_ch_q;
        frame_cnt_d = frame_cnt_q;
        if (wr_en_s) begin
            if (wr_ch_s == LAST_CH) begin
                exp_ch_d    = {CHANNELS_WIDTH{1'b0}};
                frame_cnt_d = wr_frm_s + {{(FRM_W-1){1'b0}}, 1'b1};
            end else begin
                exp_ch_d    = wr_ch_s + {{(CHANNELS_WIDTH-1){1'b0}}, 1'b1};
                frame_cnt_d = wr_frm_s;
            end
        end else if (clr_cnt_s) begin
            exp_ch_d    = {CHANNELS_WIDTH{1'b0}};
            frame_cnt_d = {FRM_W{1'b0}};
        end else begin
            exp_ch_d    = exp_ch_q;
            frame_cnt_d = frame_cnt_q;
        end
        buffer_selector_d = buffer_selector_q ^ bank_full_s;
        bank_ready_d      = bank_full_s;
        sync_err_d        = sync_err_q | sync_set_s;
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            write_data_q      <= 1'b0;
            exp_ch_q          <= {CHANNELS_WIDTH{1'b0}};
            frame_cnt_q       <= {FRM_W{1'b0}};
            buffer_selector_q <= 1'b0;
            bank_ready_q      <= 1'b0;
            sync_err_q        <= 1'b0;
        end else begin
            write_data_q      <= write_data;
            exp_ch_q          <= exp_ch_d;
            frame_cnt_q       <= frame_cnt_d;
            buffer_selector_q <= buffer_selector_d;
            bank_ready_q      <= bank_ready_d;
            sync_err_q        <= sync_err_d;
        end
    end

`ifdef MIC_BUFFER_OVERRUN_EN
    logic pending_q, pending_d;
    logic overrun_q, overrun_d;

    // Completion sets pending/overrun and beats a same-cycle acknowledge.
    always_comb begin
        pending_d = bank_full_s | (pending_q & ~buffer_ack);
        overrun_d = (bank_full_s & pending_q) | (overrun_q & ~buffer_ack);
    end

    // Host handshake registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            pending_q <= pending_d;
            overrun_q <= overrun_d;
        end
    end

    assign overrun = overrun_q;
`else
    logic unused_ack_s;
    assign unused_ack_s = buffer_ack;
    assign overrun      = 1'b0;
`endif

    mic_buffer_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH_BUFFER)
    ) u_ram (
        .clk    (clk),
        .resetn (resetn),
        .we     (wr_en_s & resetn),
        .waddr  ({buffer_selector_q, wr_frm_s, wr_ch_s}),
        .wdata  (data_in),
        .re     (rd_en),
        .raddr  ({~buffer_selector_q, rd_addr}),
        .rdata  (rd_data)
    );

    assign buffer_selector = buffer_selector_q;
    assign bank_ready      = bank_ready_q;
    assign sync_err        = sync_err_q;

endmodule

// File: tb/tb_mic_buffer.sv
// Directed bench for mic_buffer with 16-word banks; overrun expectations
// follow whether MIC_BUFFER_OVERRUN_EN is defined.
module tb_mic_buffer;

    import mic_array_pkg::*;

`ifdef MIC_BUFFER_OVERRUN_EN
    localparam logic OVR_EN = 1'b1;
`else
    localparam logic OVR_EN = 1'b0;
`endif

    logic        clk;
    logic        resetn;
    logic        write_data;
    logic [2:0]  channel;
    logic [15:0] data_in;
    logic        rd_en;
    logic [3:0]  rd_addr;
    logic [15:0] rd_data;
    logic        buffer_selector;
    logic        bank_ready;
    logic        buffer_ack;
    logic        overrun;
    logic        sync_err;

    int n_cmp  = 0;
    int n_fail = 0;
    int rdy_cnt = 0;

    mic_buffer #(
        .DATA_WIDTH        (16),
        .CHANNELS          (8),
        .CHANNELS_WIDTH    (3),
        .ADDR_WIDTH_BUFFER (5)
    ) dut (
        .clk             (clk),
        .resetn          (resetn),
        .write_data      (write_data),
        .channel         (channel),
        .data_in         (data_in),
        .rd_en           (rd_en),
        .rd_addr         (rd_addr),
        .rd_data         (rd_data),
        .buffer_selector (buffer_selector),
        .bank_ready      (bank_ready),
        .buffer_ack      (buffer_ack),
        .overrun         (overrun),
        .sync_err        (sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (bank_ready === 1'b1) rdy_cnt++;
    endtask

    task automatic strobe(input logic [2:0] ch, input logic [15:0] d, input logic ack);
        channel    = ch;
        data_in    = d;
        write_data = 1'b1;
        buffer_ack = ack;
        tick();
        write_data = 1'b0;
        buffer_ack = 1'b0;
        tick();
    endtask

    task automatic fill(input int n, input int first_ch, input logic [15:0] base);
        for (int i = 0; i < n; i++) begin
            strobe(3'((first_ch + i) % 8), 16'(base + 16'(i)), 1'b0);
        end
    endtask

    task automatic rd(input logic [3:0] a, input logic [15:0] exp, input string tag);
        rd_addr = a;
        rd_en   = 1'b1;
        tick();
        rd_en   = 1'b0;
        chk(tag, {16'h0000, rd_data}, {16'h0000, exp});
    endtask

    task automatic ack_pulse();
        buffer_ack = 1'b1;
        tick();
        buffer_ack = 1'b0;
        tick();
    endtask

    initial begin
        resetn     = 1'b0;
        write_data = 1'b0;
        channel    = 3'd0;
        data_in    = 16'h0000;
        rd_en      = 1'b0;
        rd_addr    = 4'd0;
        buffer_ack = 1'b0;
        repeat (3) tick();
        chk("rst_sel",    {31'd0, buffer_selector}, 32'd0);
        chk("rst_ready",  {31'd0, bank_ready},      32'd0);
        chk("rst_ovr",    {31'd0, overrun},         32'd0);
        chk("rst_sync",   {31'd0, sync_err},        32'd0);
        chk("rst_rddata", {16'd0, rd_data},         32'd0);
        resetn = 1'b1;
        tick();

        // Startup alignment then a full bank 0.
        rdy_cnt = 0;
        strobe(3'd5, 16'h0055, 1'b0);
        strobe(3'd6, 16'h0066, 1'b0);
        strobe(3'd7, 16'h0077, 1'b0);
        chk("start_idle_sel", {31'd0, buffer_selector}, 32'd0);
        fill(15, 0, 16'h1000);
        chk("fill_sel_before_last", {31'd0, buffer_selector}, 32'd0);
        chk("fill_no_early_ready",  32'(rdy_cnt), 32'd0);
        strobe(3'd7, 16'h100F, 1'b0);
        chk("fill_sel",   {31'd0, buffer_selector}, 32'd1);
        chk("fill_ready", 32'(rdy_cnt), 32'd1);
        chk("start_sync", {31'd0, sync_err}, 32'd0);
        chk("fill_ovr",   {31'd0, overrun}, 32'd0);
        for (int i = 0; i < 16; i++) begin
            rd(4'(i), 16'(16'h1000 + 16'(i)), "fill_rd");
        end
        tick();
        chk("rd_hold", {16'd0, rd_data}, 32'h0000100F);
        ack_pulse();

        // Misalignment in bank 1.
        strobe(3'd0, 16'h3000, 1'b0);
        strobe(3'd1, 16'h3001, 1'b0);
        strobe(3'd3, 16'h3BAD, 1'b0);
        chk("mis_sync",  {31'd0, sync_err}, 32'd1);
        chk("mis_state", 32'(dut.state_q), 32'(ST_IDLE));
        strobe(3'd1, 16'h3EEE, 1'b0);
        chk("mis_state_hold", 32'(dut.state_q), 32'(ST_IDLE));
        rdy_cnt = 0;
        fill(16, 0, 16'h3100);
        chk("mis_sel",   {31'd0, buffer_selector}, 32'd0);
        chk("mis_ready", 32'(rdy_cnt), 32'd1);
        chk("mis_ovr",   {31'd0, overrun}, 32'd0);
        rd(4'd0,  16'h3100, "mis_rd0");
        rd(4'd1,  16'h3101, "mis_rd1");
        rd(4'd2,  16'h3102, "mis_rd2");
        rd(4'd3,  16'h3103, "mis_rd3");
        rd(4'd15, 16'h310F, "mis_rd15");

        // Held strobe into bank 0, no ack before completion.
        channel    = 3'd0;
        data_in    = 16'h4000;
        write_data = 1'b1;
        repeat (5) tick();
        write_data = 1'b0;
        tick();
        fill(14, 1, 16'h4001);
        chk("held_sel_before_last", {31'd0, buffer_selector}, 32'd0);
        strobe(3'd7, 16'h400F, 1'b0);
        chk("held_sel", {31'd0, buffer_selector}, 32'd1);
        chk("ovr_second", {31'd0, overrun}, {31'd0, OVR_EN});
        rd(4'd0,  16'h4000, "held_rd0");
        rd(4'd1,  16'h4001, "held_rd1");
        rd(4'd15, 16'h400F, "held_rd15");

        // Completion and acknowledge in the same cycle.
        ack_pulse();
        chk("ovr_ack_clear", {31'd0, overrun}, 32'd0);
        rdy_cnt = 0;
        fill(16, 0, 16'h5000);
        chk("ovr_first_ok", {31'd0, overrun}, 32'd0);
        fill(15, 0, 16'h5100);
        strobe(3'd7, 16'h510F, 1'b1);
        chk("ovr_same_cycle", {31'd0, overrun}, {31'd0, OVR_EN});
        chk("ovr_sel",   {31'd0, buffer_selector}, 32'd1);
        chk("ovr_ready", 32'(rdy_cnt), 32'd2);

        // Reset in the middle of a fill.
        fill(10, 0, 16'h6000);
        resetn = 1'b0;
        tick();
        chk("mrst_sel",    {31'd0, buffer_selector}, 32'd0);
        chk("mrst_ready",  {31'd0, bank_ready},      32'd0);
        chk("mrst_ovr",    {31'd0, overrun},         32'd0);
        chk("mrst_sync",   {31'd0, sync_err},        32'd0);
        chk("mrst_rddata", {16'd0, rd_data},         32'd0);
        chk("mrst_state",  32'(dut.state_q), 32'(ST_IDLE));
        resetn = 1'b1;
        tick();
        rdy_cnt = 0;
        fill(15, 0, 16'h7000);
        chk("mrst_no_spurious", 32'(rdy_cnt), 32'd0);
        chk("mrst_sel_mid", {31'd0, buffer_selector}, 32'd0);
        strobe(3'd7, 16'h700F, 1'b0);
        chk("mrst_ready_once", 32'(rdy_cnt), 32'd1);
        chk("mrst_sel_done", {31'd0, buffer_selector}, 32'd1);
        rd(4'd0,  16'h7000, "mrst_rd0");
        rd(4'd10, 16'h700A, "mrst_rd10");
        rd(4'd15, 16'h700F, "mrst_rd15");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
